slt_seq_unit: RTL



---
 rtl/slt_seq_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/slt_seq_unit.sv
// rtl/slt_seq_unit.sv - multi-cycle sliced set-on-compare unit (SLT/SLTU/SEQ/SLE)
// Optional macro SLT_FLAGS_EN adds registered Diff and Flags outputs.
module slt_seq_unit #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             done,
`ifdef SLT_FLAGS_EN
   output logic [WIDTH-1:0] Diff,
   output logic [3:0]       Flags,
`endif
   output logic [WIDTH-1:0] Out
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [1:0]       op_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic             zero_q;
   logic             out_q;

   logic [IW-1:0]    base;
   logic [SLICE-1:0] a_s, nb_s;
   logic [SLICE:0]   sum;
   logic             last, accept;
   logic             cin_msb, ovf_n, sign_n, cout_n, zero_n, res;

`ifdef SLT_FLAGS_EN
   logic [WIDTH-1:0] diff_acc;
   logic [WIDTH-1:0] diff_full;
   logic [WIDTH-1:0] diff_q;
   logic [3:0]       flags_q;
`endif

   // Slice datapath: A_s + ~B_s + carry, with the carry registered between slices.
   always_comb begin
      base    = IW'(32'(cnt_q) * 32'(SLICE));
      a_s     = a_q[base +: SLICE];
      nb_s    = ~b_q[base +: SLICE];
      sum     = {1'b0, a_s} + {1'b0, nb_s} + {{SLICE{1'b0}}, carry_q};
      last    = (cnt_q == LAST);
      cout_n  = sum[SLICE];
      sign_n  = sum[SLICE-1];
      // Carry into the top bit recovered from its sum bit: s = a ^ b ^ cin.
      cin_msb = a_s[SLICE-1] ^ nb_s[SLICE-1] ^ sum[SLICE-1];
      ovf_n   = cin_msb ^ cout_n;
      zero_n  = zero_q & (sum[SLICE-1:0] == '0);
      case (op_q)
         2'b00:   res = sign_n ^ ovf_n;
         2'b01:   res = ~cout_n;
         2'b10:   res = zero_n;
         default: res = (sign_n ^ ovf_n) | zero_n;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      done    = 1'b0;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready = 1'b1;
            if (start) begin
               accept  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            ready = 1'b1;
            done  = 1'b1;
            if (start) begin
               accept  = 1'b1;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 2'b00;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b1;
         out_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op;
            cnt_q   <= '0;
            carry_q <= 1'b1;
            zero_q  <= 1'b1;
         end else if (state_q == S_RUN) begin
            carry_q <= cout_n;
            zero_q  <= zero_n;
            cnt_q   <= cnt_q + 1'b1;
            // Result is registered as DONE is entered so it is valid with the done pulse.
            if (last) begin
               out_q <= res;
            end
         end
      end
   end

   assign Out = {{(WIDTH-1){1'b0}}, out_q};

`ifdef SLT_FLAGS_EN
   always_comb begin
      diff_full                  = diff_acc;
      diff_full[base +: SLICE]   = sum[SLICE-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         diff_acc <= '0;
         diff_q   <= '0;
         flags_q  <= 4'b0000;
      end else if (state_q == S_RUN) begin
         diff_acc[base +: SLICE] <= sum[SLICE-1:0];
         if (last) begin
            diff_q  <= diff_full;
            flags_q <= {ovf_n, cout_n, sign_n, zero_n};
         end
      end
   end

   assign Diff  = diff_q;
   assign Flags = flags_q;
`endif

endmodule
